// File: rtl/rsa_uart_pkg.sv
// Shared types and helpers for the RSA result UART transmitter.
package rsa_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Integer floor of clock cycles per bit period.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/rsa_uart_tx_byte.sv
// 8N1 framer for a single character. tx_done marks the final cycle of the
// stop bit; a tx_start seen in that cycle chains the next frame with no gap.
//
//   state | meaning
//   IDLE  | line high, waiting for tx_start
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (high) for CLKS_PER_BIT cycles
//   NEXT  | zero-cycle decision, resolved in the last STOP cycle; never held
module uart_tx_byte
    import rsa_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_end;

    // Bit-period boundary and frame-status decode.
    always_comb begin
        baud_end = (baud_cnt == BAUD_LAST);
        tx_done  = (state == STOP) && baud_end;
        tx_busy  = (state != IDLE);
    end

    // Frame sequencer; the line is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        state    <= START;
                        shreg    <= tx_byte;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        uart_txd <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state    <= STOP;
                            bit_cnt  <= '0;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            shreg    <= {1'b0, shreg[7:1]};
                            uart_txd <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (tx_start) begin
                            state    <= START;
                            shreg    <= tx_byte;
                            uart_txd <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rsa_uart_tx.sv
// Serializes a 2*WIDTH-bit RSA result onto uart_txd, most significant
// character first. Define RSA_TX_HEX_EN to send uppercase ASCII hex
// followed by CR LF instead of raw bytes.
module rsa_uart_tx
    import rsa_uart_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2*WIDTH-1:0] data,
    output logic               uart_txd,
    output logic               busy,
    output logic               done
);

    localparam int WBITS = 2 * WIDTH;
`ifdef RSA_TX_HEX_EN
    localparam int NCHAR = WBITS / 4 + 2;
`else
    localparam int NCHAR = WBITS / 8;
`endif
    localparam int IW = $clog2(NCHAR + 1);

    logic [WBITS-1:0] word_buf;
    logic [IW-1:0]    char_idx;
    logic             accept;
    logic             last_char;
    logic             tx_start;
    logic             tx_busy;
    logic             tx_done;
    logic [7:0]       tx_byte;

    // Character idx of the word, counting from the most significant end.
    function automatic logic [7:0] char_of(input logic [WBITS-1:0] w, input int idx);
        logic [WBITS-1:0] sh;
`ifdef RSA_TX_HEX_EN
        sh = w >> (WBITS - 4 - 4 * idx);
        if (idx < WBITS / 4)
            return nibble_to_ascii(sh[3:0]);
        else if (idx == WBITS / 4)
            return ASCII_CR;
        else
            return ASCII_LF;
`else
        sh = w >> (WBITS - 8 - 8 * idx);
        return sh[7:0];
`endif
    endfunction

    // Acceptance excludes the done cycle; mid-word the next character is
    // handed to the framer in its last stop cycle so frames abut.
    always_comb begin
        accept    = start && !busy && !done && !tx_busy;
        last_char = (char_idx == IW'(NCHAR - 1));
        tx_start  = accept || (busy && tx_done && !last_char);
        if (accept)
            tx_byte = char_of(data, 0);
        else
            tx_byte = char_of(word_buf, last_char ? 0 : int'(char_idx) + 1);
    end

    // Word buffer, character counter and completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_buf <= '0;
            char_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                word_buf <= data;
                char_idx <= '0;
                busy     <= 1'b1;
            end else if (busy && tx_done) begin
                if (last_char) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    char_idx <= '0;
                end else begin
                    char_idx <= char_idx + IW'(1);
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_framer (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .uart_txd(uart_txd)
    );

endmodule

// File: tb/tb_rsa_uart_tx.sv
// Scoreboard bench for rsa_uart_tx: stimulus pushes expected characters and
// done cycles, independent monitors decode the line and watch done.
module tb_rsa_uart_tx;

    localparam int CPB = 10;
`ifdef RSA_TX_HEX_EN
    localparam int NCHAR = 18;
`else
    localparam int NCHAR = 8;
`endif
    localparam int T = 1 + NCHAR * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] data;
    logic        txd;
    logic        busy;
    logic        done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int         done_q[$];

    rsa_uart_tx #(
        .WIDTH   (32),
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .start   (start),
        .data    (data),
        .uart_txd(txd),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: characters of a word as they should appear on the line.
    function automatic void push_expected(input logic [63:0] w);
        string hexs = "0123456789ABCDEF";
`ifdef RSA_TX_HEX_EN
        for (int i = 0; i < 16; i++) exp_q.push_back(hexs[(w >> (60 - 4 * i)) & 64'hF]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        if (hexs.len() == 0) exp_q.push_back(8'h00);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'((w >> (56 - 8 * i)) & 64'hFF));
`endif
    endfunction

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [63:0] w, output int k);
        start = 1'b1;
        data  = w;
        k     = cyc;
        push_expected(w);
        done_q.push_back(k + T);
    endtask

    task automatic run_word(input logic [63:0] w);
        int k;
        issue(w, k);
        at_cycle(k + 1);
        start = 1'b0;
        @(negedge clk);
        chk("first_txd", txd, 0);
        chk("first_busy", busy, 1);
        at_cycle(k + T - 1);
        @(negedge clk);
        chk("last_busy", busy, 1);
        at_cycle(k + T + 3);
    endtask

    // Line decoder: one frame per falling edge, abandoned on reset.
    initial begin
        logic samp[10*CPB];
        logic aborted, shape_ok;
        logic [7:0] byte_v;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && txd === 1'b0) begin
                samp[0] = 1'b0;
                aborted = 1'b0;
                for (int i = 1; i < 10 * CPB; i++) begin
                    @(negedge clk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = txd;
                end
                if (!aborted) begin
                    shape_ok = 1'b1;
                    for (int i = 0; i < CPB; i++) begin
                        if (samp[i] !== 1'b0) shape_ok = 1'b0;
                        if (samp[9*CPB+i] !== 1'b1) shape_ok = 1'b0;
                    end
                    for (int b = 0; b < 8; b++) begin
                        byte_v[b] = samp[CPB*(1+b)];
                        for (int i = 0; i < CPB; i++)
                            if (samp[CPB*(1+b)+i] !== byte_v[b]) shape_ok = 1'b0;
                    end
                    chk("frame_shape", shape_ok, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %0h expected none", byte_v);
                    end else begin
                        chk("char", byte_v, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Done monitor: every pulse must match a scheduled completion cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse at %0d expected none", cyc);
            end else begin
                chk("done_cycle", cyc, done_q.pop_front());
            end
            chk("busy_at_done", busy, 0);
        end
    end

    initial begin
        int k, k2;
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        at_cycle(4);
        rst = 1'b0;
        at_cycle(6);

        run_word(64'h0000_0000_0000_0002);

        // Second start while busy must not disturb the latched word.
        issue(64'h0123_4567_89AB_CDEF, k);
        at_cycle(k + 1);
        start = 1'b0;
        at_cycle(k + 50);
        start = 1'b1;
        data  = {$urandom, $urandom};
        at_cycle(k + 51);
        start = 1'b0;
        data  = {$urandom, $urandom};
        at_cycle(k + T + 3);

        for (int n = 0; n < 3; n++) run_word({$urandom, $urandom});

        // Reset mid-DATA of the second character.
        issue({$urandom, $urandom}, k);
        at_cycle(k + 1);
        start = 1'b0;
        at_cycle(k + 155);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        at_cycle(k + 156);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        at_cycle(k + 200);
        run_word({$urandom, $urandom});

        // Start coincident with done is dropped; one cycle later it is taken.
        issue({$urandom, $urandom}, k);
        at_cycle(k + 1);
        start = 1'b0;
        at_cycle(k + T);
        start = 1'b1;
        data  = {$urandom, $urandom};
        @(negedge clk);
        chk("done_seen", done, 1);
        at_cycle(k + T + 1);
        issue({$urandom, $urandom}, k2);
        @(negedge clk);
        chk("no_accept_on_done", txd, 1);
        at_cycle(k2 + 1);
        start = 1'b0;
        @(negedge clk);
        chk("late_accept_txd", txd, 0);
        chk("late_accept_busy", busy, 1);
        at_cycle(k2 + T + 3);

        chk("chars_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
